temp_sensor_bcd: RTL and testbench
==================================

TEMP_SENSOR_BCD -- requirements
Module: temp_sensor_bcd

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, DRP-ready wait limit in clk cycles; used only with TEMP_TIMEOUT_EN.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 trigger  in  1  measurement request level; may stay high for many cycles (e.g. a whole frame).
REQ-005 daddr  out  7  DRP address to XADC.
REQ-006 den  out  1  DRP enable, one-cycle pulse.
REQ-007 dwe  out  1  DRP write enable; tied 0.
REQ-008 di  out  16  DRP write data; tied 16'h0000.
REQ-009 do_data  in  16  DRP read data; temperature code in do_data[15:4].
REQ-010 drdy  in  1  DRP read-data-valid strobe.
REQ-011 temp_ent_bcd  out  12  integer degrees C, 3 BCD digits, hundreds in [11:8].
REQ-012 temp_dec_bcd  out  4  tenths of degree C, 1 BCD digit.
REQ-013 testigo  out  1  toggles on every committed measurement.
REQ-014 busy  out  1  high from accepted trigger edge until commit or abort.
REQ-015 timeout_err  out  1  sticky DRP-timeout flag; constant 0 without TEMP_TIMEOUT_EN.

Function
REQ-016 Rising edge of trigger (registered previous value 0, current 1) while IDLE starts a measurement; edges while busy are dropped, not queued.
REQ-017 FSM states IDLE -> REQ -> WAIT -> CONV -> BCD -> COMMIT -> IDLE.
REQ-018 REQ: daddr=7'h00 and den=1 for exactly one cycle, beginning the cycle after the edge is detected.
REQ-019 WAIT: hold den=0; on drdy=1 capture code=do_data[15:4] and go to CONV; drdy outside WAIT is ignored.
REQ-020 CONV (1 cycle): tenths = ((code*80635)>>16) - 2732, 29-bit unsigned product; if the shifted value is <2732, tenths=0 (no negative results).
REQ-021 BCD: sequential double-dabble, 12 iterations, 1 per cycle, 12-bit binary to 16-bit BCD.
REQ-022 COMMIT: temp_ent_bcd=BCD[15:4], temp_dec_bcd=BCD[3:0], toggle testigo, all updated in one edge; outputs otherwise hold their last committed values.
REQ-023 Latency: outputs change on the 14th rising edge after the edge that samples drdy=1.
REQ-024 Maximum result is 230.6 (code 12'hFFF); no overflow handling is needed beyond REQ-020.

Reset
REQ-025 rst=1 forces IDLE, den=0, daddr=0, busy=0, temp_ent_bcd=0, temp_dec_bcd=0, testigo=0, timeout_err=0, edge register=0.
REQ-026 rst mid-measurement aborts with no commit; a drdy arriving after reset is ignored.
REQ-027 If trigger is already high when rst deasserts, no measurement starts until trigger goes low and then high again.

Configuration
REQ-028 Macro TEMP_TIMEOUT_EN defined: a WAIT cycle counter runs; after TIMEOUT_CYCLES cycles without drdy, the FSM returns to IDLE, sets timeout_err, and leaves outputs and testigo unchanged. timeout_err clears only on rst.
REQ-029 TEMP_TIMEOUT_EN undefined: no counter exists, WAIT lasts indefinitely, and timeout_err=0.

Structure
REQ-030 Package temp_sensor_pkg holds the FSM state typedef and constants XADC_TEMP_ADDR=7'h00, TEMP_SCALE=80635, TEMP_OFFSET_TENTHS=2732, BCD_ITER=12.
REQ-031 One sub-module, bin2bcd_seq, implements the start/done sequential converter of REQ-021.

Verification
REQ-032 Trigger edge, drdy 3 cycles after den, do_data=16'h9770 (code 2423) -> temp_ent_bcd=12'h024, temp_dec_bcd=4'h9, testigo toggles once.
REQ-033 Code 12'hFFF -> 12'h230/4'h6. Code 0 and code 2221 -> 12'h000/4'h0. Code 2222 -> 12'h000/4'h1.
REQ-034 trigger held high for 1000 cycles -> exactly one den pulse; a second edge during BCD -> no second den.
REQ-035 rst asserted during WAIT, then drdy pulsed -> outputs stay 0 and testigo stays 0; the next trigger edge measures normally.
REQ-036 With TEMP_TIMEOUT_EN and no drdy -> after 255 WAIT cycles busy=0, timeout_err=1, previous outputs retained; without the macro -> busy stays 1.
REQ-037 Latency check: commit on exactly the 14th edge after drdy; den width is exactly 1 cycle; dwe=0 throughout.

Source files
------------

// File: rtl/temp_sensor_pkg.sv
// Shared types and constants for the XADC temperature-to-BCD reader.
// Contents: FSM state type, DRP/temperature constants, one double-dabble step helper.
package temp_sensor_pkg;

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CODE_W   = 12;
    localparam int unsigned BIN_W    = 12;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned PROD_W   = 29;
    localparam int unsigned SCALED_W = PROD_W - 16;

    localparam logic [ADDR_W-1:0] XADC_TEMP_ADDR = 7'h00;
    localparam int unsigned TEMP_SCALE         = 80635;
    localparam int unsigned TEMP_OFFSET_TENTHS = 2732;
    localparam int unsigned BCD_ITER           = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CONV,
        ST_BCD,
        ST_COMMIT
    } state_t;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in bit_in.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/temp_sensor_bcd_if.sv
// DRP bus between the temperature reader (master) and the XADC (slave).
// Signals: daddr/den/dwe/di driven by master; do_data/drdy driven by slave.
interface temp_sensor_bcd_if;
    import temp_sensor_pkg::*;

    logic [ADDR_W-1:0] daddr;
    logic              den;
    logic              dwe;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] do_data;
    logic              drdy;

    modport master (output daddr, output den, output dwe, output di,
                    input  do_data, input drdy);
    modport slave  (input  daddr, input den, input dwe, input di,
                    output do_data, output drdy);
endinterface

// File: rtl/temp_sensor_bcd_bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter, one iteration per cycle.
// Ports: clk, rst (sync, active-high), start (loads bin and runs iteration 1),
//        bin[11:0], bcd[15:0] (holds last result), done (one-cycle pulse after iteration 12).
module bin2bcd_seq
    import temp_sensor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);
    localparam int unsigned CNT_W = $clog2(BCD_ITER + 1);

    logic [BIN_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    // The load cycle already consumes the MSB so that 12 iterations take 12 edges.
    always_comb begin
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (start) begin
            bcd_d    = dabble_step('0, bin[BIN_W-1]);
            shift_d  = {bin[BIN_W-2:0], 1'b0};
            cnt_d    = CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            bcd_d   = dabble_step(bcd_q, shift_q[BIN_W-1]);
            shift_d = {shift_q[BIN_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BCD_ITER - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;
endmodule

// File: rtl/temp_sensor_bcd.sv
// XADC die-temperature reader: on a trigger rising edge issues one DRP read,
// converts the code to tenths of a degree C and commits it as BCD.
// Ports: clk, rst (sync, active-high), trigger (level), drp (DRP master modport),
//        temp_ent_bcd[11:0], temp_dec_bcd[3:0], testigo (toggles per commit),
//        busy, timeout_err (sticky).
// Optional: define TEMP_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without drdy.
module temp_sensor_bcd
    import temp_sensor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    temp_sensor_bcd_if.master        drp,
    output logic [11:0]              temp_ent_bcd,
    output logic [3:0]               temp_dec_bcd,
    output logic                     testigo,
    output logic                     busy,
    output logic                     timeout_err
);
    state_t             state_q, state_d;
    logic               trig_q, trig_d;
    logic               armed_q, armed_d;
    logic [ADDR_W-1:0]  daddr_q, daddr_d;
    logic               den_q, den_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [11:0]        ent_q, ent_d;
    logic [3:0]         dec_q, dec_d;
    logic               testigo_q, testigo_d;
    logic               busy_q, busy_d;

    logic               trig_edge_c;
    logic               conv_start_c;
    logic [PROD_W-1:0]  prod_c;
    logic [SCALED_W-1:0] scaled_c;
    logic [BIN_W-1:0]   tenths_c;
    logic [BCD_W-1:0]   bcd_c;
    logic               bcd_done_c;

`ifdef TEMP_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    // Armed only once trigger has been seen low, so a level held through reset never fires.
    assign trig_edge_c = trigger & ~trig_q & armed_q;

    // Kelvin-tenths scaling; clamp below 0 C.
    assign prod_c   = PROD_W'(code_q) * PROD_W'(TEMP_SCALE);
    assign scaled_c = prod_c[PROD_W-1:16];
    assign tenths_c = (scaled_c < SCALED_W'(TEMP_OFFSET_TENTHS)) ? '0
                    : BIN_W'(scaled_c - SCALED_W'(TEMP_OFFSET_TENTHS));

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_c),
        .bin   (tenths_c),
        .bcd   (bcd_c),
        .done  (bcd_done_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        trig_d       = trigger;
        armed_d      = armed_q | ~trigger;
        daddr_d      = daddr_q;
        den_d        = 1'b0;
        code_d       = code_q;
        ent_d        = ent_q;
        dec_d        = dec_q;
        testigo_d    = testigo_q;
        conv_start_c = 1'b0;
`ifdef TEMP_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trig_edge_c) begin
                    state_d = ST_REQ;
                    den_d   = 1'b1;
                    daddr_d = XADC_TEMP_ADDR;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
`ifdef TEMP_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (drp.drdy) begin
                    code_d  = drp.do_data[15:4];
                    state_d = ST_CONV;
`ifdef TEMP_TIMEOUT_EN
                end else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
`endif
                end
            end
            ST_CONV: begin
                conv_start_c = 1'b1;
                state_d      = ST_BCD;
            end
            ST_BCD: begin
                if (bcd_done_c) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                ent_d     = bcd_c[15:4];
                dec_d     = bcd_c[3:0];
                testigo_d = ~testigo_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            trig_q    <= 1'b0;
            armed_q   <= 1'b0;
            daddr_q   <= '0;
            den_q     <= 1'b0;
            code_q    <= '0;
            ent_q     <= '0;
            dec_q     <= '0;
            testigo_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TEMP_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_d;
            armed_q   <= armed_d;
            daddr_q   <= daddr_d;
            den_q     <= den_d;
            code_q    <= code_d;
            ent_q     <= ent_d;
            dec_q     <= dec_d;
            testigo_q <= testigo_d;
            busy_q    <= busy_d;
`ifdef TEMP_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign drp.daddr    = daddr_q;
    assign drp.den      = den_q;
    assign drp.dwe      = 1'b0;
    assign drp.di       = '0;
    assign temp_ent_bcd = ent_q;
    assign temp_dec_bcd = dec_q;
    assign testigo      = testigo_q;
    assign busy         = busy_q;
`ifdef TEMP_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`else
    assign timeout_err  = 1'b0;
`endif
endmodule

// File: tb/tb_temp_sensor_bcd.sv
// Bench for temp_sensor_bcd: table of spec vectors plus random codes through a
// commit scoreboard, and hand sequences for reset, trigger-level and timeout corners.
module tb_temp_sensor_bcd;
    logic        clk;
    logic        rst;
    logic        trigger;
    logic [11:0] temp_ent_bcd;
    logic [3:0]  temp_dec_bcd;
    logic        testigo;
    logic        busy;
    logic        timeout_err;

    temp_sensor_bcd_if drp_if();

    temp_sensor_bcd dut (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger),
        .drp          (drp_if),
        .temp_ent_bcd (temp_ent_bcd),
        .temp_dec_bcd (temp_dec_bcd),
        .testigo      (testigo),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] code;
        int          dly;
        logic [11:0] ent;
        logic [3:0]  dec;
    } vec_t;

    typedef struct {
        logic [11:0] ent;
        logic [3:0]  dec;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          den_pulses = 0;
    int          den_wide = 0;
    int          dwe_bad = 0;
    logic        den_prev = 1'b0;
    logic        testigo_prev = 1'b0;
    logic [11:0] last_ent = '0;
    logic [3:0]  last_dec = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic then decimal digit split.
    function automatic logic [15:0] model(input logic [11:0] code);
        longint p;
        longint s;
        int     t;
        p = longint'(code) * 80635;
        s = p >>> 16;
        t = (s < 2732) ? 0 : int'(s - 2732);
        return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    // Commit monitor: every testigo toggle must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            testigo_prev = testigo;
            den_prev     = 1'b0;
        end else begin
            if (drp_if.dwe !== 1'b0 || drp_if.di !== 16'h0000) dwe_bad++;
            if (drp_if.den === 1'b1 && den_prev) den_wide++;
            if (drp_if.den === 1'b1 && !den_prev) den_pulses++;
            den_prev = (drp_if.den === 1'b1);
            if (testigo !== testigo_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got ent=%0h dec=%0h with no pending measurement",
                             temp_ent_bcd, temp_dec_bcd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("commit_ent", 32'(temp_ent_bcd), 32'(e.ent));
                    check("commit_dec", 32'(temp_dec_bcd), 32'(e.dec));
                    check("commit_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            testigo_prev = testigo;
        end
    end

    task automatic wait_den();
        int n = 0;
        while (drp_if.den !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check("den_seen", 32'(drp_if.den), 32'd1);
    endtask

    task automatic pulse_drdy(input logic [11:0] code, input logic [11:0] ent, input logic [3:0] dec);
        exp_t e;
        drp_if.do_data = {code, 4'h0};
        drp_if.drdy    = 1'b1;
        e.ent = ent;
        e.dec = dec;
        e.cyc = cyc + 1 + 14;
        sb.push_back(e);
        last_ent = ent;
        last_dec = dec;
        tick(1);
        drp_if.drdy    = 1'b0;
        drp_if.do_data = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic measure(input logic [11:0] code, input int dly,
                           input logic [11:0] ent, input logic [3:0] dec, input bit drop_trig);
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        wait_den();
        tick(dly);
        pulse_drdy(code, ent, dec);
        wait_idle();
        if (drop_trig) trigger = 1'b0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [15:0] m;
        logic [11:0] code;
        int          p;

        vecs[0] = '{12'd2423, 3, 12'h024, 4'h9};
        vecs[1] = '{12'hFFF,  3, 12'h230, 4'h6};
        vecs[2] = '{12'd0,    1, 12'h000, 4'h0};
        vecs[3] = '{12'd2221, 2, 12'h000, 4'h0};
        vecs[4] = '{12'd2222, 5, 12'h000, 4'h1};

        rst = 1'b1;
        trigger = 1'b0;
        drp_if.drdy = 1'b0;
        drp_if.do_data = 16'h0000;
        tick(3);
        check("rst_ent", 32'(temp_ent_bcd), 32'h0);
        check("rst_dec", 32'(temp_dec_bcd), 32'h0);
        check("rst_testigo", 32'(testigo), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_den", 32'(drp_if.den), 32'h0);
        check("rst_daddr", 32'(drp_if.daddr), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        tick(2);

        // Reset during WAIT, then a stray drdy: nothing may commit.
        trigger = 1'b1;
        wait_den();
        check("den_addr", 32'(drp_if.daddr), 32'h0);
        tick(1);
        check("busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        drp_if.do_data = 16'h9770;
        drp_if.drdy = 1'b1;
        tick(1);
        drp_if.drdy = 1'b0;
        tick(30);
        check("abort_ent", 32'(temp_ent_bcd), 32'h0);
        check("abort_dec", 32'(temp_dec_bcd), 32'h0);
        check("abort_testigo", 32'(testigo), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        trigger = 1'b0;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            measure(vecs[i].code, vecs[i].dly, vecs[i].ent, vecs[i].dec, 1'b1);
        end

        for (int i = 0; i < 6; i++) begin
            code = 12'($urandom_range(0, 4095));
            m = model(code);
            measure(code, int'($urandom_range(1, 5)), m[15:4], m[3:0], 1'b1);
        end

        // Trigger held high for 1000 cycles: a single read.
        p = den_pulses;
        m = model(12'd2600);
        measure(12'd2600, 3, m[15:4], m[3:0], 1'b0);
        tick(960);
        check("held_trigger_den_pulses", 32'(den_pulses - p), 32'd1);
        check("held_trigger_busy", 32'(busy), 32'd0);

        // Second edge while converting is dropped.
        p = den_pulses;
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        wait_den();
        tick(2);
        m = model(12'd3000);
        pulse_drdy(12'd3000, m[15:4], m[3:0]);
        tick(4);
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        tick(1);
        wait_idle();
        tick(5);
        check("bcd_edge_den_pulses", 32'(den_pulses - p), 32'd1);
        check("bcd_edge_busy", 32'(busy), 32'd0);

        // Trigger already high across reset release must not start a read.
        p = den_pulses;
        trigger = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        check("held_rst_den_pulses", 32'(den_pulses - p), 32'd0);
        check("held_rst_busy", 32'(busy), 32'd0);
        m = model(12'd2423);
        measure(12'd2423, 3, m[15:4], m[3:0], 1'b1);

        // No drdy at all.
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        wait_den();
        tick(300);
`ifdef TEMP_TIMEOUT_EN
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
`else
        check("no_timeout_busy", 32'(busy), 32'd1);
        check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif
        check("stall_ent_kept", 32'(temp_ent_bcd), 32'(last_ent));
        check("stall_dec_kept", 32'(temp_dec_bcd), 32'(last_dec));
        trigger = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("final_rst_busy", 32'(busy), 32'd0);
        check("final_rst_err", 32'(timeout_err), 32'd0);
        check("final_rst_ent", 32'(temp_ent_bcd), 32'h0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("den_width", 32'(den_wide), 32'd0);
        check("dwe_di_zero", 32'(dwe_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
